// File: rtl/demux_reg_if.sv
// Handshake bundle for demux_reg: one input stream steered to two registered output slots.
// The master side drives the input word and the sink ready strobes; the slave side is the demux itself.
interface demux_reg_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic             sel;
    logic             d_ready;

    logic [WIDTH-1:0] q0;
    logic             q0_valid;
    logic             q0_ready;

    logic [WIDTH-1:0] q1;
    logic             q1_valid;
    logic             q1_ready;

    logic [7:0]       cnt0;
    logic [7:0]       cnt1;

    modport master (
        output d, d_valid, sel, q0_ready, q1_ready,
        input  d_ready, q0, q0_valid, q1, q1_valid, cnt0, cnt1
    );

    modport slave (
        input  d, d_valid, sel, q0_ready, q1_ready,
        output d_ready, q0, q0_valid, q1, q1_valid, cnt0, cnt1
    );
endinterface

// File: rtl/demux_reg.sv
// 1-to-2 registered demultiplexer with an independent single-entry slot per output.
// Optional per-output transfer counters are built when DEMUX_REG_STATS_EN is defined.
module demux_reg #(
    parameter int WIDTH = 1
) (
    input logic        clk,
    input logic        rst_n,
    demux_reg_if.slave bus
);
    localparam int NUM_SLOTS = 2;

    logic [WIDTH-1:0]     slot_data_reg [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_valid_reg;
    logic [NUM_SLOTS-1:0] sink_ready;
    logic [NUM_SLOTS-1:0] load;
    logic [NUM_SLOTS-1:0] drain;
    logic                 d_ready_int;
    logic                 accept;

    // Ready looks only at the addressed slot, so a stalled slot never blocks the other.
    assign sink_ready  = {bus.q1_ready, bus.q0_ready};
    assign d_ready_int = ~slot_valid_reg[bus.sel] | sink_ready[bus.sel];
    assign accept      = bus.d_valid & d_ready_int;
    assign bus.d_ready = d_ready_int;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign load[gi]  = accept & (bus.sel == 1'(gi));
            assign drain[gi] = slot_valid_reg[gi] & sink_ready[gi];

            // A load wins over a drain so a same-cycle refill keeps valid high with no bubble.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_valid_reg[gi] <= 1'b0;
                    slot_data_reg[gi]  <= '0;
                end else if (load[gi]) begin
                    slot_valid_reg[gi] <= 1'b1;
                    slot_data_reg[gi]  <= bus.d;
                end else if (drain[gi]) begin
                    slot_valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.q0       = slot_data_reg[0];
    assign bus.q0_valid = slot_valid_reg[0];
    assign bus.q1       = slot_data_reg[1];
    assign bus.q1_valid = slot_valid_reg[1];

`ifdef DEMUX_REG_STATS_EN
    logic [7:0] cnt_reg [NUM_SLOTS];

    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_cnt
            // Free-running 8-bit count of completed output transfers; wraps naturally.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= 8'd0;
                end else if (drain[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 8'd1;
                end
            end
        end
    endgenerate

    assign bus.cnt0 = cnt_reg[0];
    assign bus.cnt1 = cnt_reg[1];
`else
    assign bus.cnt0 = 8'd0;
    assign bus.cnt1 = 8'd0;
`endif
endmodule

// File: tb/tb_demux_reg.sv
// Directed bench for demux_reg: vector table plus hand-written multi-cycle sequences.
// Counter expectations follow DEMUX_REG_STATS_EN so the bench suits either build.
module tb_demux_reg;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    demux_reg_if #(.WIDTH(W)) bus ();
    demux_reg_if #(.WIDTH(1)) bus1 ();

    demux_reg #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Narrow instance mirrors the main stimulus on bit 0 for the single-bit steering case.
    demux_reg #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    assign bus1.d        = bus.d[0];
    assign bus1.d_valid  = bus.d_valid;
    assign bus1.sel      = bus.sel;
    assign bus1.q0_ready = bus.q0_ready;
    assign bus1.q1_ready = bus.q1_ready;

    typedef struct {
        logic [7:0] d;
        logic       dv;
        logic       sel;
        logic       r0;
        logic       r1;
        logic       e_rdy;
        logic       e_v0;
        logic [7:0] e_q0;
        logic       e_v1;
        logic [7:0] e_q1;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference occupancy and transfer counts, advanced once per clock edge.
    logic       m_v   [2];
    logic [7:0] m_cnt [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic logic [7:0] exp_cnt(input int idx);
`ifdef DEMUX_REG_STATS_EN
        return m_cnt[idx];
`else
        return 8'd0;
`endif
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_v[k]   = 1'b0;
            m_cnt[k] = 8'd0;
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic dv, input logic sel,
                         input logic r0, input logic r1);
        bus.d        = d;
        bus.d_valid  = dv;
        bus.sel      = sel;
        bus.q0_ready = r0;
        bus.q1_ready = r1;
        #1;
    endtask

    task automatic tick();
        logic [1:0] rdy;
        logic       dr;
        logic       acc;
        logic       nv  [2];
        logic       dn  [2];
        rdy = {bus.q1_ready, bus.q0_ready};
        dr  = ~m_v[bus.sel] | rdy[bus.sel];
        acc = bus.d_valid & dr;
        for (int k = 0; k < 2; k++) begin
            dn[k] = m_v[k] & rdy[k];
            if (acc && (bus.sel == 1'(k))) nv[k] = 1'b1;
            else if (dn[k])                nv[k] = 1'b0;
            else                           nv[k] = m_v[k];
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_v[k] = nv[k];
                if (dn[k]) m_cnt[k] = m_cnt[k] + 8'd1;
            end
        end
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 8'hA5};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 8'hA5};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 8'hA5};
        vecs[3] = '{8'h77, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'hA5};
        vecs[4] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b1, 8'hC3};
        vecs[5] = '{8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 8'hC3};
        vecs[6] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 8'hC3};
        vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 8'hC3};
        vecs[8] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 8'hC3};
        vecs[9] = '{8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 8'hC3};

        model_clear();
        rst_n = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();

        // Reset state
        chk("rst q0_valid", bus.q0_valid, 0);
        chk("rst q1_valid", bus.q1_valid, 0);
        chk("rst q0", bus.q0, 0);
        chk("rst q1", bus.q1, 0);
        chk("rst cnt0", bus.cnt0, 0);
        chk("rst cnt1", bus.cnt1, 0);
        chk("rst d_ready sel0", bus.d_ready, 1);
        drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst d_ready sel1", bus.d_ready, 1);
        rst_n = 1'b1;

        // Basic steering, single-cycle latency
        drive(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("steer d_ready", bus.d_ready, 1);
        tick();
        chk("steer q0", bus.q0, 8'h01);
        chk("steer q0_valid", bus.q0_valid, 1);
        chk("steer q1_valid", bus.q1_valid, 0);
        chk("steer w1 q0", bus1.q0, 1);
        chk("steer w1 q0_valid", bus1.q0_valid, 1);
        chk("steer w1 q1_valid", bus1.q1_valid, 0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].d, vecs[i].dv, vecs[i].sel, vecs[i].r0, vecs[i].r1);
            chk($sformatf("vec%0d d_ready", i), bus.d_ready, vecs[i].e_rdy);
            tick();
            chk($sformatf("vec%0d q0_valid", i), bus.q0_valid, vecs[i].e_v0);
            chk($sformatf("vec%0d q0", i), bus.q0, vecs[i].e_q0);
            chk($sformatf("vec%0d q1_valid", i), bus.q1_valid, vecs[i].e_v1);
            chk($sformatf("vec%0d q1", i), bus.q1, vecs[i].e_q1);
        end
        chk("table cnt0", bus.cnt0, exp_cnt(0));
        chk("table cnt1", bus.cnt1, exp_cnt(1));

        // Backpressure on slot 0 for five cycles, then release
        drive(8'h42, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(8'h99, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d d_ready", i), bus.d_ready, 0);
            chk($sformatf("bp%0d q0", i), bus.q0, 8'h42);
            chk($sformatf("bp%0d q0_valid", i), bus.q0_valid, 1);
            tick();
        end
        bus.q0_ready = 1'b1;
        #1;
        chk("bp release d_ready", bus.d_ready, 1);
        tick();
        chk("bp refill q0", bus.q0, 8'h99);
        chk("bp refill q0_valid", bus.q0_valid, 1);

        // Slot 1 traffic while slot 0 stays stalled
        drive(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("indep d_ready", bus.d_ready, 1);
        tick();
        chk("indep q1_valid", bus.q1_valid, 1);
        chk("indep q1", bus.q1, 8'h01);
        chk("indep q0_valid", bus.q0_valid, 1);
        chk("indep q0", bus.q0, 8'h99);
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("indep drain q1_valid", bus.q1_valid, 0);
        chk("indep hold q0", bus.q0, 8'h99);

        // Back-to-back alternating stream
        drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 8; i++) begin
            logic s;
            logic [7:0] dw;
            s  = i[0];
            dw = 8'h10 + 8'(i);
            drive(dw, 1'b1, s, 1'b1, 1'b1);
            chk($sformatf("b2b%0d d_ready", i), bus.d_ready, 1);
            tick();
            if (s) begin
                chk($sformatf("b2b%0d q1", i), bus.q1, dw);
                chk($sformatf("b2b%0d q1_valid", i), bus.q1_valid, 1);
                chk($sformatf("b2b%0d q0_valid", i), bus.q0_valid, 0);
            end else begin
                chk($sformatf("b2b%0d q0", i), bus.q0, dw);
                chk($sformatf("b2b%0d q0_valid", i), bus.q0_valid, 1);
                chk($sformatf("b2b%0d q1_valid", i), bus.q1_valid, 0);
            end
        end
        drive(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("b2b cnt0", bus.cnt0, exp_cnt(0));
        chk("b2b cnt1", bus.cnt1, exp_cnt(1));

        // Counter wrap: 256 transfers on output 1 from a fresh reset
        rst_n = 1'b0;
        #1;
        chk("wrap pre cnt1", bus.cnt1, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            drive(8'(i), (i < 256) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b1);
            tick();
            if (i == 128 || i == 255 || i == 256)
                chk($sformatf("wrap%0d cnt1", i), bus.cnt1, exp_cnt(1));
        end
        chk("wrap final cnt1", bus.cnt1, 0);
        chk("wrap final cnt0", bus.cnt0, 0);

        // Fill both slots with nonzero counters, then reset between edges
        drive(8'h21, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        drive(8'h23, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        drive(8'h24, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("mid full q0_valid", bus.q0_valid, 1);
        chk("mid full q1_valid", bus.q1_valid, 1);
        chk("mid q0", bus.q0, 8'h23);
        chk("mid q1", bus.q1, 8'h24);
        chk("mid cnt0", bus.cnt0, exp_cnt(0));
        chk("mid cnt1", bus.cnt1, exp_cnt(1));
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("async q0_valid", bus.q0_valid, 0);
        chk("async q1_valid", bus.q1_valid, 0);
        chk("async q0", bus.q0, 0);
        chk("async q1", bus.q1, 0);
        chk("async cnt0", bus.cnt0, 0);
        chk("async cnt1", bus.cnt1, 0);
        chk("async d_ready", bus.d_ready, 1);
        tick();
        rst_n = 1'b1;
        drive(8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        chk("resume q1", bus.q1, 8'h55);
        chk("resume q1_valid", bus.q1_valid, 1);
        chk("resume q0_valid", bus.q0_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
